// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width/sign codes, default memory depth and the request legality check.
package lsu_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Encoding and alignment errors only; the address range check depends on
    // the instance depth and is done in the top level.
    function automatic logic encoding_error(logic write, logic [2:0] funct3, logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:         err = 1'b0;
            F3_H:         err = offset[0];
            F3_W:         err = (offset != 2'b00);
            F3_BU:        err = write;
            F3_HU:        err = write | offset[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3     : access width/sign code
//   offset     : byte offset within the word (addr[1:0])
//   word       : word read from data memory
//   wdata      : right-aligned store data
//   load_data  : addressed lane of word, sign/zero extended
//   store_data : word with the store lane merged in (wdata unmodified for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h000000, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0000, half_lane};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_data = wdata;
        case (funct3)
            F3_B: begin
                store_data = word;
                store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_data = word;
                store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between a core request port and a word-wide data
// memory with combinational read. Sub-word stores are read-modify-write.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata : access description
//   resp_valid/rdata/err  : one-cycle completion pulse with load data / error
//   MemRead/MemWrite      : single-cycle registered memory strobes
//   mem_addr/wdata/rdata  : data memory word index, write word, read word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned MEM_AW      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

    lsu_state_e          state_q, state_d;
    logic                write_q;
    logic [2:0]          funct3_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                resp_valid_q, resp_valid_d;

    logic                accept;
    logic                acc_err;
    logic [31:0]         load_data;
    logic [31:0]         store_data;

    assign accept  = req_valid && (state_q == IDLE);
    assign acc_err = encoding_error(req_write, req_funct3, req_addr[1:0])
                     || (64'(req_addr) >= BYTE_LIMIT);

    always_comb begin
        state_d      = state_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (acc_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else if (req_write && (req_funct3 == F3_W)) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = READ;
                        mem_read_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and response flag are flops of their own so the outputs never
    // glitch on multi-bit state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[MEM_AW+1:0];
                wdata_q  <= req_wdata;
                err_q    <= acc_err;
            end
            if (state_q == READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign req_ready  = (state_q == IDLE);
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign mem_addr   = addr_q[MEM_AW+1:2];
    assign mem_wdata  = store_data;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !write_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 128-word data memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [128];
    int          rd_total = 0;
    int          wr_total = 0;
    int          resp_total = 0;
    logic [8:0]  last_rd_addr = '0;
    logic [8:0]  last_wr_addr = '0;

    // Results of the most recent access.
    int          lat;
    int          waits;
    int          n_rd;
    int          n_wr;
    logic [31:0] got_rdata;
    logic        got_err;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 9'd128) ? mem[mem_addr[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite) begin
            if (mem_addr < 9'd128) mem[mem_addr[6:0]] <= mem_wdata;
            last_wr_addr <= mem_addr;
            wr_total     <= wr_total + 1;
        end
        if (MemRead) begin
            last_rd_addr <= mem_addr;
            rd_total     <= rd_total + 1;
        end
        if (resp_valid) resp_total <= resp_total + 1;
    end

    // Drive one access, keep garbage on req_* while busy, and record latency
    // (edges from the accepting edge to resp_valid), strobe counts and result.
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
        int rd0;
        int wr0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        waits = 0;
        while (!req_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        rd0 = rd_total;
        wr0 = wr_total;
        @(posedge clk);
        #1;
        req_write  = $urandom_range(0, 1) == 1;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_rd = rd_total - rd0;
        n_wr = wr_total - wr0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++;
            $display("FAIL reset_resp got v=%b e=%b exp 0/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin errors++;
            $display("FAIL reset_strobes got r=%b w=%b exp 0/0", MemRead, MemWrite); end
        checks++; if (mem_addr !== 9'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_mem got a=%h d=%h exp 0/0", mem_addr, mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sw_lw();
        do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (lat != 2) begin errors++;
            $display("FAIL sw_latency got %0d exp 2", lat); end
        checks++; if (n_wr != 1 || n_rd != 0) begin errors++;
            $display("FAIL sw_strobes got rd=%0d wr=%0d exp 0/1", n_rd, n_wr); end
        checks++; if (last_wr_addr !== 9'd4 || mem[4] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL sw_mem got a=%0d d=%h exp 4/deadbeef", last_wr_addr, mem[4]); end
        checks++; if (got_rdata !== 32'h0 || got_err !== 1'b0) begin errors++;
            $display("FAIL sw_resp got d=%h e=%b exp 0/0", got_rdata, got_err); end
        do_access(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (lat != 2) begin errors++;
            $display("FAIL lw_latency got %0d exp 2", lat); end
        checks++; if (got_rdata !== 32'hDEADBEEF || got_err !== 1'b0) begin errors++;
            $display("FAIL lw_data got %h e=%b exp deadbeef/0", got_rdata, got_err); end
        checks++; if (n_rd != 1 || n_wr != 0 || last_rd_addr !== 9'd4) begin errors++;
            $display("FAIL lw_strobes got rd=%0d wr=%0d a=%0d exp 1/0/4", n_rd, n_wr,
                     last_rd_addr); end
    endtask

    task automatic test_byte();
        do_access(1'b1, 3'b010, 32'h20, 32'h11223344);
        do_access(1'b1, 3'b000, 32'h22, 32'hFFFFFFAA);
        checks++; if (lat != 3) begin errors++;
            $display("FAIL sb_latency got %0d exp 3", lat); end
        checks++; if (n_rd != 1 || n_wr != 1) begin errors++;
            $display("FAIL sb_strobes got rd=%0d wr=%0d exp 1/1", n_rd, n_wr); end
        checks++; if (mem[8] !== 32'h11AA3344) begin errors++;
            $display("FAIL sb_merge got %h exp 11aa3344", mem[8]); end
        do_access(1'b0, 3'b100, 32'h22, 32'h0);
        checks++; if (got_rdata !== 32'h000000AA) begin errors++;
            $display("FAIL lbu got %h exp 000000aa", got_rdata); end
        do_access(1'b0, 3'b000, 32'h22, 32'h0);
        checks++; if (got_rdata !== 32'hFFFFFFAA) begin errors++;
            $display("FAIL lb got %h exp ffffffaa", got_rdata); end
        do_access(1'b0, 3'b000, 32'h23, 32'h0);
        checks++; if (got_rdata !== 32'h00000011) begin errors++;
            $display("FAIL lb_lane3 got %h exp 00000011", got_rdata); end
    endtask

    task automatic test_half();
        do_access(1'b1, 3'b010, 32'h30, 32'h00000000);
        do_access(1'b1, 3'b001, 32'h32, 32'h12348001);
        checks++; if (lat != 3 || mem[12] !== 32'h80010000) begin errors++;
            $display("FAIL sh_merge got lat=%0d d=%h exp 3/80010000", lat, mem[12]); end
        do_access(1'b0, 3'b001, 32'h32, 32'h0);
        checks++; if (got_rdata !== 32'hFFFF8001) begin errors++;
            $display("FAIL lh got %h exp ffff8001", got_rdata); end
        do_access(1'b0, 3'b101, 32'h32, 32'h0);
        checks++; if (got_rdata !== 32'h00008001) begin errors++;
            $display("FAIL lhu got %h exp 00008001", got_rdata); end
        do_access(1'b0, 3'b101, 32'h30, 32'h0);
        checks++; if (got_rdata !== 32'h00000000) begin errors++;
            $display("FAIL lhu_low got %h exp 00000000", got_rdata); end
    endtask

    task automatic test_errors();
        logic        ew [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  ef [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ea [5] = '{32'h13, 32'h15, 32'h200, 32'h10, 32'h10};
        for (int i = 0; i < 5; i++) begin
            do_access(ew[i], ef[i], ea[i], 32'hFFFFFFFF);
            checks++;
            if (got_err !== 1'b1 || lat != 1 || got_rdata !== 32'h0 || n_rd != 0 || n_wr != 0)
            begin
                errors++;
                $display("FAIL err_case%0d got e=%b lat=%0d d=%h rd=%0d wr=%0d exp 1/1/0/0/0",
                         i, got_err, lat, got_rdata, n_rd, n_wr);
            end
        end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL err_no_write got %h exp deadbeef", mem[4]); end
    endtask

    task automatic test_boundary();
        do_access(1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D);
        do_access(1'b0, 3'b010, 32'h1FC, 32'h0);
        checks++; if (got_err !== 1'b0 || got_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL lw_top got e=%b d=%h exp 0/cafef00d", got_err, got_rdata); end
        checks++; if (last_rd_addr !== 9'd127) begin errors++;
            $display("FAIL lw_top_addr got %0d exp 127", last_rd_addr); end
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_idle_ready got %b exp 1", req_ready); end
        // Start the next request while the first is still in RESP.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        @(posedge clk); #1;
        req_addr = 32'h10;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_resp_ready got %b exp 0", req_ready); end
        got_rdata = resp_rdata;
        checks++; if (lat != 2 || got_rdata !== 32'h11AA3344) begin errors++;
            $display("FAIL b2b_first got lat=%0d d=%h exp 2/11aa3344", lat, got_rdata); end
        do_access(1'b0, 3'b010, 32'h1FC, 32'h0);
        checks++; if (waits != 1 || got_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL b2b_second got waits=%0d d=%h exp 1/cafef00d", waits, got_rdata); end
    endtask

    task automatic test_reset_mid_write();
        int resp0;
        int n;
        resp0 = resp_total;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!MemWrite && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (MemWrite !== 1'b1) begin errors++;
            $display("FAIL rst_write_seen got %b exp 1", MemWrite); end
        rst_n = 1'b0;
        #1;
        checks++; if (MemWrite !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_async got w=%b rdy=%b exp 0/1", MemWrite, req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || resp_total != resp0) begin errors++;
            $display("FAIL rst_no_resp got rdy=%b resps=%0d exp 1/0", req_ready,
                     resp_total - resp0); end
        checks++; if (mem[8] !== 32'h11AA3344) begin errors++;
            $display("FAIL rst_mem_kept got %h exp 11aa3344", mem[8]); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
